load_store_unit: RTL and testbench

Initiator side of the data-memory interface. Accepts one load/store request from the datapath and sequences MemRead/MemWrite cycles to the word-addressed data memory. Adds byte and halfword access, with read-modify-write for sub-word stores and sign/zero extension for sub-word loads. Sits between the datapath's MEM stage and the data memory.

---
 rtl/load_store_unit_pkg.sv | 32 +++
 rtl/load_store_unit_if.sv | 30 +++
 rtl/load_store_unit_lane_mux.sv | 39 +++
 rtl/load_store_unit.sv | 122 ++++++++++++
 tb/tb_load_store_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// request legality check.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Misalignment, the reserved size code and out-of-range words all fail.
  function automatic logic access_err(input logic [1:0] size,
                                      input logic [31:0] addr,
                                      input logic [31:0] mem_words);
    logic bad;
    bad = 1'b0;
    if (size == SZ_ILL) bad = 1'b1;
    if ((size == SZ_HALF) && addr[0]) bad = 1'b1;
    if ((size == SZ_WORD) && (addr[1:0] != 2'b00)) bad = 1'b1;
    if ({2'b00, addr[31:2]} >= mem_words) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Datapath request/response signals plus the data-memory bus of the LSU.
interface load_store_unit_if;

  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] MemReadData;

  modport slave (
    input  req, we, size, sign_ext, addr, wdata, MemReadData,
    output busy, done, err, rdata, MemAddress, MemWriteData, MemWrite, MemRead
  );

  modport master (
    output req, we, size, sign_ext, addr, wdata, MemReadData,
    input  busy, done, err, rdata, MemAddress, MemWriteData, MemWrite, MemRead
  );

endinterface

// File: rtl/load_store_unit_lane_mux.sv
// Sub-word lane handling: extract/extend a loaded lane and merge store data
// into a fetched word (little-endian lanes).
import load_store_unit_pkg::*;

module lsu_lane_mux (
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: load_data = word;
    endcase

    store_word = word;
    case (size)
      SZ_BYTE: store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: one request at a time, sequenced as RD and/or WR
// memory cycles; sub-word stores use read-modify-write.
import load_store_unit_pkg::*;

module load_store_unit #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic              clock,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_err;
  logic [31:0] lane_word;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_err = access_err(bus.size, bus.addr, 32'(MEM_WORDS));

  // Loads extract straight from the bus in RD so rdata is ready with done.
  assign lane_word = (state_q == ST_RD) ? bus.MemReadData : word_q;

  lsu_lane_mux u_lane_mux (
    .word       (lane_word),
    .addr_lo    (addr_q[1:0]),
    .size       (size_q),
    .sign_ext   (sign_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          if (req_err)                 state_d = ST_DONE;
          else if (!bus.we)            state_d = ST_RD;
          else if (bus.size == SZ_WORD) state_d = ST_WR;
          else                         state_d = ST_RD;
        end
      end
      ST_RD:   state_d = we_q ? ST_WR : ST_DONE;
      ST_WR:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy         = (state_q != ST_IDLE);
    bus.done         = (state_q == ST_DONE);
    bus.err          = (state_q == ST_DONE) && err_q;
    bus.rdata        = rdata_q;
    bus.MemAddress   = {addr_q[31:2], 2'b00};
    bus.MemRead      = (state_q == ST_RD);
    bus.MemWrite     = (state_q == ST_WR);
    bus.MemWriteData = (state_q == ST_WR) ? store_word : 32'h0;
  end

  always_comb begin
    we_d    = we_q;
    size_d  = size_q;
    sign_d  = sign_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if ((state_q == ST_IDLE) && bus.req) begin
      we_d    = bus.we;
      size_d  = bus.size;
      sign_d  = bus.sign_ext;
      addr_d  = bus.addr;
      wdata_d = bus.wdata;
      err_d   = req_err;
    end
    if (state_q == ST_RD) begin
      word_d = bus.MemReadData;
      if (!we_q) rdata_d = load_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      we_q    <= we_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level model of
// memory contents, results and latency.
module tb_load_store_unit;

  logic clock;
  logic reset;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] exp_rdata;
  int          n_checks;
  int          n_errors;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign bus.MemReadData = mem[bus.MemAddress[11:2]];

  always @(negedge clock) begin
    if (bus.MemWrite) mem[bus.MemAddress[11:2]] <= bus.MemWriteData;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && a[0]) return 1'b1;
    if (sz == 2'd2 && a[1:0] != 2'b00) return 1'b1;
    return (a >> 2) >= 32'd1024;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                         input logic [31:0] a, input logic sg);
    logic [31:0] v;
    logic [4:0]  sh;
    if (sz == 2'd0) begin
      sh = {a[1:0], 3'b000};
      v  = (w >> sh) & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      sh = {a[1], 4'b0000};
      v  = (w >> sh) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [1:0] sz,
                                          input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    logic [4:0]  sh;
    if (sz == 2'd2) return wd;
    sh   = {a[1:0], 3'b000};
    mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic run_txn(input logic t_we, input logic [1:0] t_size, input logic t_sign,
                         input logic [31:0] t_addr, input logic [31:0] t_wdata, input bit hold);
    logic        e_err;
    int          e_lat, e_rd, e_wr;
    logic [9:0]  idx;
    logic [31:0] e_wword;
    int          cyc, lat, n_rd, n_wr, n_both, extra_done;
    logic [31:0] wr_seen;

    idx     = t_addr[11:2];
    e_err   = m_err(t_size, t_addr);
    e_lat   = e_err ? 1 : ((t_we && t_size != 2'd2) ? 3 : 2);
    e_rd    = (!e_err && (!t_we || t_size != 2'd2)) ? 1 : 0;
    e_wr    = (!e_err && t_we) ? 1 : 0;
    e_wword = m_merge(ref_mem[idx], t_size, t_addr, t_wdata);
    if (!e_err && !t_we) exp_rdata = m_load(ref_mem[idx], t_size, t_addr, t_sign);
    if (!e_err && t_we) ref_mem[idx] = e_wword;

    @(negedge clock);
    bus.we = t_we; bus.size = t_size; bus.sign_ext = t_sign;
    bus.addr = t_addr; bus.wdata = t_wdata; bus.req = 1'b1;
    @(posedge clock); #1;
    if (!hold) bus.req = 1'b0;
    cyc = 1; lat = 0; n_rd = 0; n_wr = 0; n_both = 0; wr_seen = 32'h0;
    while (cyc <= 8) begin
      if (bus.MemRead) n_rd++;
      if (bus.MemWrite) begin n_wr++; wr_seen = bus.MemWriteData; end
      if (bus.MemRead && bus.MemWrite) n_both++;
      if (bus.done) begin lat = cyc; break; end
      @(posedge clock); #1;
      cyc++;
    end
    chk("latency", 32'(lat), 32'(e_lat));
    chk("err", {31'b0, bus.err}, {31'b0, e_err});
    chk("rdata", bus.rdata, exp_rdata);
    chk("read_cycles", 32'(n_rd), 32'(e_rd));
    chk("write_cycles", 32'(n_wr), 32'(e_wr));
    chk("rd_wr_overlap", 32'(n_both), 32'd0);
    if (e_wr == 1) chk("write_data", wr_seen, e_wword);
    if (hold) begin
      @(negedge clock);
      bus.req = 1'b0;
    end
    extra_done = 0;
    for (int k = 0; k < (hold ? 4 : 1); k++) begin
      @(posedge clock); #1;
      if (bus.done || bus.busy) extra_done++;
    end
    chk("idle_after", 32'(extra_done), 32'd0);
    chk("mem_word", mem[idx], ref_mem[idx]);
  endtask

  task automatic reset_in_wr();
    int dones;
    @(negedge clock);
    bus.we = 1'b1; bus.size = 2'd0; bus.sign_ext = 1'b0;
    bus.addr = 32'h20; bus.wdata = 32'hAB; bus.req = 1'b1;
    @(posedge clock); #1;
    bus.req = 1'b0;
    @(posedge clock); #1;
    chk("rst_wr_entered", {31'b0, bus.MemWrite}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_memwrite", {31'b0, bus.MemWrite}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    @(negedge clock); #1;
    reset = 1'b0;
    exp_rdata = 32'h0;
    chk("rst_mem", mem[8], ref_mem[8]);
    dones = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      if (bus.done) dones++;
    end
    chk("rst_no_done", 32'(dones), 32'd0);
    chk("rst_rdata", bus.rdata, 32'h0);
  endtask

  initial begin
    logic [31:0] r_addr;
    n_checks = 0; n_errors = 0; exp_rdata = 32'h0;
    reset = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'd0; bus.sign_ext = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'h8899AABB;
    ref_mem[4] = 32'h8899AABB;
    #3;
    chk("reset_busy", {31'b0, bus.busy}, 32'd0);
    chk("reset_done", {31'b0, bus.done}, 32'd0);
    chk("reset_err", {31'b0, bus.err}, 32'd0);
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_memrd_wr", {30'b0, bus.MemRead, bus.MemWrite}, 32'd0);
    chk("reset_memaddr", bus.MemAddress, 32'h0);
    chk("reset_memwdata", bus.MemWriteData, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    run_txn(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b0);
    chk("plan_lb_sext", bus.rdata, 32'hFFFFFFAA);
    run_txn(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0);
    chk("plan_lh_zext", bus.rdata, 32'h00008899);
    run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("plan_lw", bus.rdata, 32'h8899AABB);
    run_txn(1'b1, 2'd0, 1'b0, 32'h13, 32'h55, 1'b0);
    chk("plan_sb_mem", mem[4], 32'h5599AABB);
    run_txn(1'b1, 2'd1, 1'b0, 32'h11, 32'h1234, 1'b0);
    chk("plan_sh_mis_mem", mem[4], 32'h5599AABB);
    run_txn(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1'b0);
    run_txn(1'b0, 2'd3, 1'b0, 32'h14, 32'h0, 1'b0);
    run_txn(1'b1, 2'd1, 1'b0, 32'h22, 32'hBEEF, 1'b1);
    reset_in_wr();

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) r_addr = $urandom;
      else r_addr = 32'($urandom_range(0, 63));
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              r_addr, $urandom, ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
